// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared screen geometry, pixel record and arbiter state encoding for the
// framebuffer write path.
//   SCREEN_W / SCREEN_H : visible screen size in pixels
//   X_W / Y_W / COLOR_W : coordinate and colour widths of the write port
//   pixel_t             : one framebuffer write {x, y, color}
//   state_e             : write-arbiter mode (IDLE arbitration / CLEAR sweep)
// -----------------------------------------------------------------------------
package vga_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOR_W  = 3;

    typedef struct packed {
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic [COLOR_W-1:0] color;
    } pixel_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    // True when the pixel lies inside a w x h screen.
    function automatic logic pix_in_range(input pixel_t p, input int w, input int h);
        return (int'(p.x) < w) && (int'(p.y) < h);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Generic N-way round-robin arbiter. The search starts at the pointer and
// wraps upward; after a grant to index i the pointer moves to (i+1) mod N.
// Ports:
//   clk_i    : clock, rising edge
//   rst_i    : synchronous active-high reset (pointer -> 0)
//   en_i     : arbitration allowed this cycle (0 forces no grant, pointer holds)
//   req_i    : per-requester request
//   grant_o  : one-hot or zero grant (combinational)
//   idx_o    : index of the granted requester
//   valid_o  : a grant is issued this cycle
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int N  = 3,
    localparam int IW = $clog2(N)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic [N-1:0]  req_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;

    // Rotating-priority search and next-pointer computation.
    always_comb begin
        int   cand;
        int   win;
        logic hit;
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        ptr_d   = ptr_q;
        win     = 0;
        cand    = 0;
        hit     = 1'b0;
        for (int off = 0; off < N; off++) begin
            cand    = (int'(ptr_q) + off >= N) ? int'(ptr_q) + off - N : int'(ptr_q) + off;
            hit     = en_i && !valid_o && req_i[cand];
            win     = hit ? cand : win;
            valid_o = valid_o | hit;
        end
        if (valid_o) begin
            grant_o[win] = 1'b1;
            idx_o        = IW'(win);
            ptr_d        = IW'((win + 1) % N);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/vga_write_arbiter.sv
// -----------------------------------------------------------------------------
// vga_write_arbiter
// Shares the single framebuffer pixel-write port between NUM_REQ requesters
// with round-robin arbitration, one pixel per cycle, registered outputs.
// Granted pixels outside the screen are consumed and flagged on oob.
// Optional clear engine (macro VGA_ARB_CLEAR_EN) sweeps the screen row-major
// with one colour; while it runs requests are stalled (grant=0).
// Ports:
//   clk_proc, rst                 : clock and synchronous active-high reset
//   req/req_x/req_y/req_color     : packed per-requester write requests
//   grant                         : combinational one-hot accept
//   clear_start, clear_color      : clear trigger and fill colour
//   busy                          : clear engine running
//   vga_we/vga_x/vga_y/vga_dout   : registered framebuffer write port
//   oob                           : registered out-of-range drop pulse
// -----------------------------------------------------------------------------
module vga_write_arbiter
    import vga_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int SCREEN_W = vga_pkg::SCREEN_W,
    parameter int SCREEN_H = vga_pkg::SCREEN_H
) (
    input  logic                   clk_proc,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*8-1:0]   req_x,
    input  logic [NUM_REQ*7-1:0]   req_y,
    input  logic [NUM_REQ*3-1:0]   req_color,
    output logic [NUM_REQ-1:0]     grant,
    input  logic                   clear_start,
    input  logic [2:0]             clear_color,
    output logic                   busy,
    output logic                   vga_we,
    output logic [7:0]             vga_x,
    output logic [6:0]             vga_y,
    output logic [2:0]             vga_dout,
    output logic                   oob
);

    localparam int IW = $clog2(NUM_REQ);

    logic          arb_en_s;
    logic          arb_valid_s;
    logic [IW-1:0] arb_idx_s;
    pixel_t        gpix_s;
    logic          clearing_s;
    pixel_t        clr_pix_s;

    logic          we_d,  we_q;
    logic          oob_d, oob_q;
    pixel_t        out_d, out_q;

`ifdef VGA_ARB_CLEAR_EN
    state_e               state_q, state_d;
    logic [X_W-1:0]       cx_q, cx_d;
    logic [Y_W-1:0]       cy_q, cy_d;
    logic [COLOR_W-1:0]   ccol_q, ccol_d;

    // A clear_start in IDLE pre-empts arbitration for that cycle.
    assign arb_en_s   = ~rst & (state_q == IDLE) & ~clear_start;
    assign clearing_s = (state_q == CLEAR);
    assign busy       = (state_q == CLEAR);
    assign clr_pix_s  = '{x: cx_q, y: cy_q, color: ccol_q};

    // Clear FSM next state and row-major sweep counters.
    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        ccol_d  = ccol_q;
        case (state_q)
            IDLE: begin
                if (clear_start) begin
                    state_d = CLEAR;
                    cx_d    = '0;
                    cy_d    = '0;
                    ccol_d  = clear_color;
                end else begin
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                if (cx_q == X_W'(SCREEN_W - 1)) begin
                    cx_d = '0;
                    if (cy_q == Y_W'(SCREEN_H - 1)) begin
                        cy_d    = '0;
                        state_d = IDLE;
                    end else begin
                        cy_d = cy_q + 1'b1;
                    end
                end else begin
                    cx_d = cx_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Clear FSM state and counter registers.
    always_ff @(posedge clk_proc) begin
        if (rst) begin
            state_q <= IDLE;
            cx_q    <= '0;
            cy_q    <= '0;
            ccol_q  <= '0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            ccol_q  <= ccol_d;
        end
    end
`else
    logic unused_clear_s;

    assign unused_clear_s = ^{clear_start, clear_color};
    assign arb_en_s       = ~rst;
    assign clearing_s     = 1'b0;
    assign busy           = 1'b0;
    assign clr_pix_s      = '0;
`endif

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .clk_i   (clk_proc),
        .rst_i   (rst),
        .en_i    (arb_en_s),
        .req_i   (req),
        .grant_o (grant),
        .idx_o   (arb_idx_s),
        .valid_o (arb_valid_s)
    );

    assign gpix_s = '{x:     req_x[int'(arb_idx_s)*X_W +: X_W],
                      y:     req_y[int'(arb_idx_s)*Y_W +: Y_W],
                      color: req_color[int'(arb_idx_s)*COLOR_W +: COLOR_W]};

    // Next write-port values; coordinates hold whenever no write issues.
    always_comb begin
        we_d  = 1'b0;
        oob_d = 1'b0;
        out_d = out_q;
        if (clearing_s) begin
            we_d  = 1'b1;
            out_d = clr_pix_s;
        end else if (arb_valid_s) begin
            if (pix_in_range(gpix_s, SCREEN_W, SCREEN_H)) begin
                we_d  = 1'b1;
                out_d = gpix_s;
            end else begin
                oob_d = 1'b1;
            end
        end else begin
            out_d = out_q;
        end
    end

    // Registered framebuffer write port.
    always_ff @(posedge clk_proc) begin
        if (rst) begin
            we_q  <= 1'b0;
            oob_q <= 1'b0;
            out_q <= '0;
        end else begin
            we_q  <= we_d;
            oob_q <= oob_d;
            out_q <= out_d;
        end
    end

    assign vga_we   = we_q;
    assign oob      = oob_q;
    assign vga_x    = out_q.x;
    assign vga_y    = out_q.y;
    assign vga_dout = out_q.color;

endmodule

// File: tb/tb_vga_write_arbiter.sv
module tb_vga_write_arbiter;

    localparam int N = 3;
    localparam int W = 160;
    localparam int H = 120;
`ifdef VGA_ARB_CLEAR_EN
    localparam bit CLR_ON = 1'b1;
`else
    localparam bit CLR_ON = 1'b0;
`endif

    logic           clk_proc = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req;
    logic [N*8-1:0] req_x;
    logic [N*7-1:0] req_y;
    logic [N*3-1:0] req_color;
    logic [N-1:0]   grant;
    logic           clear_start = 1'b0;
    logic [2:0]     clear_color = 3'd0;
    logic           busy;
    logic           vga_we;
    logic [7:0]     vga_x;
    logic [6:0]     vga_y;
    logic [2:0]     vga_dout;
    logic           oob;

    vga_write_arbiter #(.NUM_REQ(N), .SCREEN_W(W), .SCREEN_H(H)) dut (
        .clk_proc    (clk_proc),
        .rst         (rst),
        .req         (req),
        .req_x       (req_x),
        .req_y       (req_y),
        .req_color   (req_color),
        .grant       (grant),
        .clear_start (clear_start),
        .clear_color (clear_color),
        .busy        (busy),
        .vga_we      (vga_we),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_dout    (vga_dout),
        .oob         (oob)
    );

    always #5 clk_proc = ~clk_proc;

    // Requester-side stimulus state
    bit rqb[N];
    int rx[N];
    int ry[N];
    int rc[N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req[i]             = rqb[i];
            req_x[i*8 +: 8]    = rx[i][7:0];
            req_y[i*7 +: 7]    = ry[i][6:0];
            req_color[i*3 +: 3] = rc[i][2:0];
        end
    end

    // Reference model state
    int ptr, clr_left, clr_k, clr_col;
    int ex, ey, ec;
    bit ewe, eoob;
    int last_win;
    int gcount[N];
    int busy_seen;
    int n_checks = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // One clock: check grant/busy mid-cycle, then registered outputs after the edge.
    task automatic cycle();
        int  win, bestd, d;
        bit  start, busy_exp;
        #4;
        busy_exp = (clr_left > 0);
        start    = CLR_ON && (clear_start === 1'b1) && !busy_exp;
        win      = -1;
        bestd    = N;
        if (!busy_exp && !start) begin
            for (int i = 0; i < N; i++) begin
                d = (i - ptr + N) % N;
                if (rqb[i] && d < bestd) begin
                    bestd = d;
                    win   = i;
                end
            end
        end
        chk("grant", grant, (win >= 0) ? (32'd1 << win) : 32'd0);
        chk("busy", busy, busy_exp);
        if (busy === 1'b1) busy_seen++;
        ewe  = 1'b0;
        eoob = 1'b0;
        if (busy_exp) begin
            ewe = 1'b1;
            ex  = clr_k % W;
            ey  = clr_k / W;
            ec  = clr_col;
            clr_k++;
            clr_left--;
        end else if (start) begin
            clr_left = W * H;
            clr_k    = 0;
            clr_col  = clear_color;
        end else if (win >= 0) begin
            ptr = (win + 1) % N;
            gcount[win]++;
            if (rx[win] < W && ry[win] < H) begin
                ewe = 1'b1;
                ex  = rx[win];
                ey  = ry[win];
                ec  = rc[win];
            end else begin
                eoob = 1'b1;
            end
        end
        last_win = win;
        @(posedge clk_proc);
        #1;
        chk("vga_we", vga_we, ewe);
        chk("oob", oob, eoob);
        chk("vga_x", vga_x, ex);
        chk("vga_y", vga_y, ey);
        chk("vga_dout", vga_dout, ec);
    endtask

    task automatic do_reset();
        clear_start = 1'b0;
        rst = 1'b1;
        @(posedge clk_proc);
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_we", vga_we, 0);
        chk("rst_oob", oob, 0);
        chk("rst_x", vga_x, 0);
        chk("rst_y", vga_y, 0);
        chk("rst_dout", vga_dout, 0);
        rst = 1'b0;
        ptr = 0; clr_left = 0; clr_k = 0; clr_col = 0;
        ex = 0; ey = 0; ec = 0;
        for (int i = 0; i < N; i++) gcount[i] = 0;
    endtask

    task automatic set_req(input int i, input bit r, input int x, input int y, input int c);
        rqb[i] = r; rx[i] = x; ry[i] = y; rc[i] = c;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 0, 0, 0);
        #1;
        do_reset();

        // Single requester held with constant data
        set_req(0, 1'b1, 10, 20, 5);
        for (int k = 0; k < 6; k++) cycle();

        // Fairness: all requesters held from reset
        set_req(0, 1'b0, 0, 0, 0);
        do_reset();
        set_req(0, 1'b1, 1, 2, 1);
        set_req(1, 1'b1, 3, 4, 2);
        set_req(2, 1'b1, 5, 6, 3);
        for (int k = 0; k < 30; k++) cycle();
        for (int i = 0; i < N; i++) chk("fair_count", gcount[i], 10);

        // Out-of-range x, then out-of-range y
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 0, 0, 0);
        do_reset();
        set_req(1, 1'b1, 160, 5, 4);
        cycle();
        set_req(1, 1'b0, 0, 0, 0);
        cycle();
        set_req(1, 1'b1, 5, 120, 6);
        cycle();
        set_req(1, 1'b0, 0, 0, 0);
        set_req(2, 1'b1, 159, 119, 7);
        cycle();
        set_req(2, 1'b0, 0, 0, 0);
        cycle();

        // Randomized traffic with handshake-respecting requesters
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++) begin
                if (last_win == i || !rqb[i])
                    set_req(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 175)),
                            int'($urandom_range(0, 127)), int'($urandom_range(0, 7)));
            end
            cycle();
        end

`ifdef VGA_ARB_CLEAR_EN
        // Full clear with all requesters pending
        do_reset();
        set_req(0, 1'b1, 11, 12, 1);
        set_req(1, 1'b1, 21, 22, 3);
        set_req(2, 1'b1, 31, 32, 5);
        cycle();
        cycle();
        busy_seen = 0;
        clear_color = 3'd2;
        clear_start = 1'b1;
        cycle();
        clear_start = 1'b0;
        clear_color = 3'd0;
        for (int k = 0; k < 19300 && clr_left > 0; k++) begin
            clear_start = (k == 100);
            cycle();
        end
        clear_start = 1'b0;
        chk("clear_done", clr_left, 0);
        chk("busy_len", busy_seen, W * H);
        for (int k = 0; k < 4; k++) cycle();

        // Reset in the middle of a clear
        clear_color = 3'd6;
        clear_start = 1'b1;
        cycle();
        clear_start = 1'b0;
        for (int k = 0; k < 5000; k++) cycle();
        do_reset();
        for (int k = 0; k < 4; k++) cycle();
`else
        // Clear pulses have no effect without the clear engine
        do_reset();
        set_req(0, 1'b1, 11, 12, 1);
        set_req(1, 1'b1, 21, 22, 3);
        set_req(2, 1'b1, 31, 32, 5);
        for (int k = 0; k < 20; k++) begin
            clear_start = (k % 5 == 1);
            clear_color = 3'(k);
            cycle();
        end
        clear_start = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_write_arbiter.md
Name: vga_write_arbiter

Overview:
Shares the single pixel-write port of vga_xy_controller between several drawing requesters inside system, for example the convolution output engine, the key-driven cursor and the note display. Arbitration is round-robin with one pixel per cycle. Outputs are registered, so the framebuffer sees at most one write per clock. An optional built-in clear engine sweeps the whole 160x120 screen to one colour.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- SCREEN_W, 160, visible width in pixels; x range 0..SCREEN_W-1.
- SCREEN_H, 120, visible height in pixels; y range 0..SCREEN_H-1.

Ports:
- clk_proc  in  1  processor clock, 50 MHz; every register uses its rising edge.
- rst  in  1  reset, synchronous, active-high.
- req  in  NUM_REQ  per-requester write request.
- req_x  in  NUM_REQ*8  packed x coordinates; requester i uses bits [8i+7:8i].
- req_y  in  NUM_REQ*7  packed y coordinates; requester i uses bits [7i+6:7i].
- req_color  in  NUM_REQ*3  packed 3-bit colours; requester i uses bits [3i+2:3i].
- grant  out  NUM_REQ  one-hot or zero; combinational; marks the request accepted this cycle.
- clear_start  in  1  single-cycle pulse that starts a screen clear.
- clear_color  in  3  fill colour, sampled on the clear_start cycle.
- busy  out  1  high while the clear engine runs.
- vga_we  out  1  registered pixel write strobe.
- vga_x  out  8  registered write x coordinate.
- vga_y  out  7  registered write y coordinate.
- vga_dout  out  3  registered write colour.
- oob  out  1  registered pulse: a granted request had an out-of-range coordinate and was dropped.

Behaviour:
- Reset values: vga_we=0, vga_x=0, vga_y=0, vga_dout=0, oob=0, busy=0, grant=0.
  - Round-robin pointer resets to 0; FSM resets to IDLE.
- Handshake:
  - A requester holds req high, with stable x/y/color, until it sees grant for one cycle.
  - The request is consumed on that cycle. The requester may present new data in the next cycle with req still high.
- Arbitration (IDLE only):
  - Search starts at the pointer and runs upward with wrap-around; the first asserted req wins.
  - After a grant to index i, the pointer becomes (i+1) mod NUM_REQ.
  - With no requests, the pointer holds and grant=0.
- Latency: a grant in cycle n produces vga_we=1 with the captured x/y/color in cycle n+1.
  - vga_we is high only in the cycle after a valid grant or a clear step; otherwise it is 0.
  - vga_x, vga_y and vga_dout hold their last values when vga_we=0.
- Range check:
  - If the granted x >= SCREEN_W or y >= SCREEN_H, the request is still granted.
  - In cycle n+1: vga_we=0 and oob=1.
- FSM states IDLE and CLEAR:
  - IDLE -> CLEAR on clear_start. Clear counters cx and cy load 0; clear_color is latched; busy=1 from the next cycle.
  - In CLEAR: grant=0 and requests are stalled, not dropped.
  - In CLEAR, each cycle issues one write at (cx, cy) in row-major order, x fastest.
  - CLEAR -> IDLE after the write at (SCREEN_W-1, SCREEN_H-1). A full clear is exactly SCREEN_W*SCREEN_H cycles.
  - busy drops in the cycle after the final write issues.
- Simultaneous events:
  - clear_start together with requests in IDLE: clear wins and no grant is issued that cycle.
  - clear_start while in CLEAR is ignored.
  - The round-robin pointer is unchanged by a clear.
- Reset mid-clear: returns to IDLE immediately, with all outputs at their reset values. The clear does not resume.

Optional Feature:
- Macro: VGA_ARB_CLEAR_EN.
- Defined: the clear engine, clear_start, clear_color and busy behave as described above.
- Undefined:
  - The clear engine and FSM are not built.
  - clear_start and clear_color are ignored; busy is tied to 0.
  - Arbitration runs every cycle.

Decomposition:
- Shared package vga_pkg holds:
  - constants SCREEN_W=160, SCREEN_H=120, X_W=8, Y_W=7, COLOR_W=3;
  - a pixel struct {x, y, color};
  - the state enum {IDLE, CLEAR}.
- One sub-module, rr_arbiter: NUM_REQ-wide round-robin grant logic with pointer update. It is reusable for the audio note-source arbitration.

Test Plan:
- Single requester: req=3'b001, x=10, y=20, color=5 held. Expect grant=001 every cycle; from cycle n+1, vga_we=1 with (10,20,5) each cycle.
- Fairness: all three req held high from reset. Expect grants 001, 010, 100, 001, ..., and each requester gets 1/3 of writes over 30 cycles.
- Out of range: requester 1 with x=160, y=5. Expect grant=010, then the next cycle shows vga_we=0 and oob=1. Repeat with y=120 and the same result.
- Clear (macro on): clear_start with clear_color=2 while req=111. Expect:
  - busy=1 for 19200 cycles and grant=0 throughout;
  - the first write at (0,0), then (159,0) followed by (0,1), and the last write at (159,119), all with colour 2;
  - after the clear, grants resume from the unchanged pointer.
- Reset mid-clear: assert rst at cycle 5000 of a clear. Expect busy=0, vga_we=0 and grant=0 next cycle, and a fresh request is granted after rst falls.
- Macro off: clear_start pulses are ignored; busy stays 0 and arbitration continues uninterrupted.
